// File: rtl/ex_muldiv_ctrl.sv
// rtl/ex_muldiv_ctrl.sv - iterative RV32M multiply/divide sequencer for the EX stage
// Shift-add multiplier and restoring divider share one accumulator pair; corner cases bypass iteration.
module ex_muldiv_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs1_val,
  input  logic [WIDTH-1:0] rs2_val,
  input  logic             flush,
  output logic             stall_req,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

  state_t           state;
  logic [2:0]       op_q;
  logic             sign_q;
  logic [5:0]       cnt;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [WIDTH-1:0] opb;

  logic             a_signed, b_signed, a_neg, b_neg, res_sign;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic             div_zero, div_ovf;
  logic [WIDTH-1:0] fast_val;

  always_comb begin
    a_signed = (op == OP_MULH) | (op == OP_MULHSU) | (op == OP_DIV) | (op == OP_REM);
    b_signed = (op == OP_MULH) | (op == OP_DIV) | (op == OP_REM);
    a_neg    = a_signed & rs1_val[WIDTH-1];
    b_neg    = b_signed & rs2_val[WIDTH-1];
    a_mag    = a_neg ? -rs1_val : rs1_val;
    b_mag    = b_neg ? -rs2_val : rs2_val;
    // Remainder takes the dividend's sign; products and quotients the XOR.
    res_sign = (op == OP_REM) ? a_neg : (a_neg ^ b_neg);
    div_zero = op[2] & (rs2_val == '0);
    div_ovf  = op[2] & ~op[0] & (rs1_val == SMIN) & (rs2_val == '1);
    // Overflow quotient equals the dividend (0x80000000), overflow remainder is zero.
    if (op[1]) fast_val = div_zero ? rs1_val : '0;
    else       fast_val = div_zero ? '1 : rs1_val;
  end

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   div_sel;
  logic [WIDTH-1:0]   div_fix;
  logic [WIDTH-1:0]   fix_val;

  always_comb begin
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : {(WIDTH+1){1'b0}});
    div_shift = {acc_hi, acc_lo[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opb};
    prod_fix  = sign_q ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
    div_sel   = op_q[1] ? acc_hi : acc_lo;
    div_fix   = sign_q ? -div_sel : div_sel;
    if (op_q[2])              fix_val = div_fix;
    else if (op_q[1:0] == 2'b00) fix_val = prod_fix[WIDTH-1:0];
    else                      fix_val = prod_fix[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      op_q   <= '0;
      sign_q <= 1'b0;
      cnt    <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      opb    <= '0;
      result <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else if (flush) begin
      state <= S_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            op_q   <= op;
            sign_q <= res_sign;
            cnt    <= '0;
            if (div_zero | div_ovf) begin
              result <= fast_val;
              done   <= 1'b1;
              state  <= S_DONE;
            end else begin
              acc_hi <= '0;
              acc_lo <= a_mag;
              opb    <= b_mag;
              busy   <= 1'b1;
              state  <= op[2] ? S_DIV : S_MUL;
            end
          end
        end
        S_MUL: begin
          acc_hi <= mul_sum[WIDTH:1];
          acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
          cnt    <= cnt + 6'd1;
          if (cnt == 6'd31) state <= S_FIX;
        end
        S_DIV: begin
          acc_hi <= div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
          acc_lo <= {acc_lo[WIDTH-2:0], ~div_diff[WIDTH]};
          cnt    <= cnt + 6'd1;
          if (cnt == 6'd31) state <= S_FIX;
        end
        S_FIX: begin
          result <= fix_val;
          busy   <= 1'b0;
          done   <= 1'b1;
          state  <= S_DONE;
        end
        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

  // DONE is left out so the instruction advances with its result.
  assign stall_req = ~rst & ~flush & (busy | ((state == S_IDLE) & start));

endmodule
